mux_16_to_1: RTL and testbench

Registered 16-to-1 word multiplexer. It selects one of sixteen 32-bit data inputs using a 4-bit select and presents the chosen word on a clocked output. It sits in the Rom-Register datapath, where it picks a register-file or ROM word for readout. The output is registered to break the combinational path from the register array to downstream logic.

---
 rtl/mux_16_to_1_if.sv | 38 +++
 rtl/mux_16_to_1.sv | 48 ++++
 tb/tb_mux_16_to_1.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux_16_to_1_if.sv
// Bundle carrying the sixteen candidate words, the select index and the registered result.
// Master drives words and select; slave (the mux) returns the selected word.
interface mux_16_to_1_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic [WIDTH-1:0] in5;
    logic [WIDTH-1:0] in6;
    logic [WIDTH-1:0] in7;
    logic [WIDTH-1:0] in8;
    logic [WIDTH-1:0] in9;
    logic [WIDTH-1:0] in10;
    logic [WIDTH-1:0] in11;
    logic [WIDTH-1:0] in12;
    logic [WIDTH-1:0] in13;
    logic [WIDTH-1:0] in14;
    logic [WIDTH-1:0] in15;
    logic [3:0]       sel;
    logic [WIDTH-1:0] out;

    modport master (
        output in0, in1, in2, in3, in4, in5, in6, in7,
        output in8, in9, in10, in11, in12, in13, in14, in15,
        output sel,
        input  out
    );

    modport slave (
        input  in0, in1, in2, in3, in4, in5, in6, in7,
        input  in8, in9, in10, in11, in12, in13, in14, in15,
        input  sel,
        output out
    );
endinterface

// File: rtl/mux_16_to_1.sv
// Registered 16:1 word mux for register-file / ROM readout.
// Latency 1 cycle; no backpressure, the output reloads every cycle.
module mux_16_to_1 #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_16_to_1_if.slave   bus
);

    logic [WIDTH-1:0] w_sel_word;
    logic [WIDTH-1:0] r_out;

    // Every select code is a real input, so the default is never reached in practice.
    always_comb begin
        w_sel_word = '0;
        case (bus.sel)
            4'd0:  w_sel_word = bus.in0;
            4'd1:  w_sel_word = bus.in1;
            4'd2:  w_sel_word = bus.in2;
            4'd3:  w_sel_word = bus.in3;
            4'd4:  w_sel_word = bus.in4;
            4'd5:  w_sel_word = bus.in5;
            4'd6:  w_sel_word = bus.in6;
            4'd7:  w_sel_word = bus.in7;
            4'd8:  w_sel_word = bus.in8;
            4'd9:  w_sel_word = bus.in9;
            4'd10: w_sel_word = bus.in10;
            4'd11: w_sel_word = bus.in11;
            4'd12: w_sel_word = bus.in12;
            4'd13: w_sel_word = bus.in13;
            4'd14: w_sel_word = bus.in14;
            4'd15: w_sel_word = bus.in15;
            default: w_sel_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_sel_word;
        end
    end

    assign bus.out = r_out;

endmodule

// File: tb/tb_mux_16_to_1.sv
// Directed bench for the registered 16:1 mux: expected words are queued as stimulus
// is applied and popped for comparison one edge later.
module tb_mux_16_to_1;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    mux_16_to_1_if #(.WIDTH(WIDTH)) bus ();

    mux_16_to_1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] in_words [16];
    logic [3:0]       sel_v;
    logic             rst_v;

    logic [WIDTH-1:0] exp_q [$];
    string            tag_q [$];

    int checks;
    int failures;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the bench-side input image to the bus and queue what the next edge must produce.
    task automatic drive(input string tag);
        bus.in0  = in_words[0];
        bus.in1  = in_words[1];
        bus.in2  = in_words[2];
        bus.in3  = in_words[3];
        bus.in4  = in_words[4];
        bus.in5  = in_words[5];
        bus.in6  = in_words[6];
        bus.in7  = in_words[7];
        bus.in8  = in_words[8];
        bus.in9  = in_words[9];
        bus.in10 = in_words[10];
        bus.in11 = in_words[11];
        bus.in12 = in_words[12];
        bus.in13 = in_words[13];
        bus.in14 = in_words[14];
        bus.in15 = in_words[15];
        bus.sel  = sel_v;
        rst_n    = rst_v;
        exp_q.push_back(rst_v ? in_words[sel_v] : '0);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        logic [WIDTH-1:0] e;
        string            t;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=queued_entry", bus.out);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, bus.out, e);
        end
    endtask

    task automatic set_identity();
        for (int k = 0; k < 16; k++) in_words[k] = WIDTH'(k);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held for two edges, then released with sel = 5.
        set_identity();
        sel_v = 4'd5;
        rst_v = 1'b0;
        drive("reset_edge1");
        tick();
        drive("reset_edge2");
        tick();
        rst_v = 1'b1;
        drive("reset_release");
        tick();

        // Full sweep of every select code.
        for (int s = 0; s < 16; s++) begin
            sel_v = 4'(s);
            drive($sformatf("sweep_%0d", s));
            tick();
        end

        // Full-width patterns pass bit-exact.
        for (int k = 0; k < 16; k++) in_words[k] = '0;
        in_words[3]  = 32'hFFFF_FFFF;
        in_words[12] = 32'h8000_0001;
        sel_v = 4'd3;
        drive("width_sel3");
        tick();
        sel_v = 4'd12;
        drive("width_sel12");
        tick();

        // Output holds between edges despite mid-cycle input and select changes.
        in_words[7] = 32'hA5A5_A5A5;
        in_words[2] = 32'h1234_5678;
        sel_v = 4'd7;
        drive("hold_capture");
        tick();
        in_words[7] = 32'h5A5A_5A5A;
        sel_v = 4'd2;
        drive("hold_next_edge");
        #2;
        check("hold_mid_cycle", bus.out, 32'hA5A5_A5A5);
        @(negedge clk);
        check("hold_before_edge", bus.out, 32'hA5A5_A5A5);
        tick();

        // Reset asserted for a single edge in the middle of a sweep.
        set_identity();
        for (int s = 0; s < 16; s++) begin
            sel_v = 4'(s);
            rst_v = (s != 9);
            drive($sformatf("midrst_%0d", s));
            tick();
        end
        rst_v = 1'b1;

        // Unselected inputs toggle freely while sel stays at 0.
        in_words[0] = 32'hDEAD_BEEF;
        sel_v = 4'd0;
        for (int c = 0; c < 20; c++) begin
            for (int k = 1; k < 16; k++) in_words[k] = $urandom;
            drive($sformatf("unsel_%0d", c));
            tick();
        end

        // Back-to-back random select and data every cycle.
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < 16; k++) in_words[k] = $urandom;
            sel_v = 4'($urandom_range(0, 15));
            drive($sformatf("rand_%0d_sel%0d", c, sel_v));
            tick();
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
